// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl
// Brief    : Byte-serial memory controller arbitrating instruction fetch and
//            load/store traffic onto a single-byte RAM/IO port. Performs
//            FETCH_BYTES fetch bursts, 1/2/4-byte loads and stores, aborts
//            speculative reads on flush and stalls IO stores on a full sink.
// Options  : RR_ARB_EN - round-robin arbitration between fetch and LSB
//            (default build: LSB has fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl #(
  parameter int         ADDR_W      = 32,
  parameter int         FETCH_BYTES = 4,
  parameter int         CNT_W       = 5,
  parameter logic [1:0] IO_HI       = 2'b11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_valid,
  output logic [8*FETCH_BYTES-1:0] if_data,
  input  logic                     lsb_req,
  input  logic                     lsb_we,
  input  logic [1:0]               lsb_size,
  input  logic [ADDR_W-1:0]        lsb_addr,
  input  logic [31:0]              lsb_wdata,
  output logic                     lsb_done,
  output logic [31:0]              lsb_rdata,
  input  logic                     io_buffer_full,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  output logic [7:0]               mem_dout,
  input  logic [7:0]               mem_din,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_STORE   = 3'd3,
    S_IO_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int               c_line_w    = 8 * FETCH_BYTES;
  localparam logic [CNT_W-1:0] c_fetch_len = CNT_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [CNT_W-1:0]    r_len, w_len;
  logic [ADDR_W-1:0]   r_base, w_base;
  logic [31:0]         r_wdata, w_wdata;
  logic                r_is_io, w_is_io;
  logic [ADDR_W-1:0]   r_mem_a, w_mem_a;
  logic                r_mem_wr, w_mem_wr;
  logic [7:0]          r_mem_dout, w_mem_dout;
  logic                r_if_valid, w_if_valid;
  logic                r_lsb_done, w_lsb_done;
  logic [c_line_w-1:0] r_if_data, w_if_data;
  logic [31:0]         r_lsb_rdata, w_lsb_rdata;

  logic [CNT_W-1:0]    w_lsb_len;
  logic [CNT_W-1:0]    w_slot;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_store_byte;
  logic                w_pick_lsb;

  // Byte i of a burst lives at base+i; the sum wraps at the address width.
  assign w_addr = r_base + ADDR_W'(r_cnt);
  // mem_din always answers the address issued one enabled edge earlier.
  assign w_slot = r_cnt - c_one;

`ifdef RR_ARB_EN
  logic r_last_lsb;

  assign w_pick_lsb = !(if_req && r_last_lsb);

  // Remember the last winner so that a tie alternates; starts as "fetch".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_lsb <= 1'b0;
    end else if (rdy && (r_state == S_IDLE) && (w_state != S_IDLE)) begin
      r_last_lsb <= (w_state != S_FETCH);
    end
  end
`else
  assign w_pick_lsb = 1'b1;
`endif

  // Decode the requested access size; size 3 behaves like a word.
  always_comb begin
    case (lsb_size)
      2'd0:    w_lsb_len = CNT_W'(1);
      2'd1:    w_lsb_len = CNT_W'(2);
      default: w_lsb_len = CNT_W'(4);
    endcase
  end

  // Select the store byte addressed by the running byte counter.
  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_store_byte = r_wdata[7:0];
      2'd1:    w_store_byte = r_wdata[15:8];
      2'd2:    w_store_byte = r_wdata[23:16];
      default: w_store_byte = r_wdata[31:24];
    endcase
  end

  // Next-state and datapath: arbitration, byte issue and byte capture.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_base      = r_base;
    w_wdata     = r_wdata;
    w_is_io     = r_is_io;
    w_mem_a     = r_mem_a;
    w_mem_wr    = 1'b0;
    w_mem_dout  = r_mem_dout;
    w_if_valid  = 1'b0;
    w_lsb_done  = 1'b0;
    w_if_data   = r_if_data;
    w_lsb_rdata = r_lsb_rdata;

    case (r_state)
      S_IDLE: begin
        if (!flush) begin
          if (lsb_req && w_pick_lsb) begin
            w_base  = lsb_addr;
            w_wdata = lsb_wdata;
            w_is_io = (lsb_addr[17:16] == IO_HI);
            w_cnt   = '0;
            if (lsb_we) begin
              w_state = S_STORE;
              w_len   = w_lsb_len;
            end else begin
              // IO reads have side effects, so only one byte is ever read.
              w_state     = S_LOAD;
              w_len       = w_is_io ? c_one : w_lsb_len;
              w_lsb_rdata = '0;
            end
          end else if (if_req) begin
            w_state = S_FETCH;
            w_base  = if_addr;
            w_len   = c_fetch_len;
            w_cnt   = '0;
          end
        end
      end

      S_FETCH, S_LOAD: begin
        if (flush) begin
          w_state = S_IDLE;
        end else begin
          if (r_cnt != '0) begin
            if (r_state == S_FETCH) begin
              for (int b = 0; b < FETCH_BYTES; b++) begin
                if (w_slot == CNT_W'(b)) w_if_data[8*b +: 8] = mem_din;
              end
            end else begin
              for (int b = 0; b < 4; b++) begin
                if (w_slot == CNT_W'(b)) w_lsb_rdata[8*b +: 8] = mem_din;
              end
            end
          end
          if (r_cnt < r_len) begin
            w_mem_a = w_addr;
            w_cnt   = r_cnt + c_one;
          end else begin
            w_state = S_DONE;
            if (r_state == S_FETCH) w_if_valid = 1'b1;
            else                    w_lsb_done = 1'b1;
          end
        end
      end

      S_STORE: begin
        if (r_cnt < r_len) begin
          if (r_is_io && io_buffer_full) begin
            w_state = S_IO_WAIT;
          end else begin
            w_mem_a    = w_addr;
            w_mem_wr   = 1'b1;
            w_mem_dout = w_store_byte;
            w_cnt      = r_cnt + c_one;
          end
        end else begin
          w_state    = S_DONE;
          w_lsb_done = 1'b1;
        end
      end

      S_IO_WAIT: begin
        if (!io_buffer_full) w_state = S_STORE;
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State register; rdy low freezes the machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state;
    end
  end

  // Datapath registers; rdy low freezes everything including mem_a.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_is_io     <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_dout  <= '0;
      r_if_valid  <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= '0;
      r_lsb_rdata <= '0;
    end else if (rdy) begin
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_base      <= w_base;
      r_wdata     <= w_wdata;
      r_is_io     <= w_is_io;
      r_mem_a     <= w_mem_a;
      r_mem_wr    <= w_mem_wr;
      r_mem_dout  <= w_mem_dout;
      r_if_valid  <= w_if_valid;
      r_lsb_done  <= w_lsb_done;
      r_if_data   <= w_if_data;
      r_lsb_rdata <= w_lsb_rdata;
    end
  end

  assign mem_a     = r_mem_a;
  // A frozen controller must never let a held write strobe repeat.
  assign mem_wr    = r_mem_wr & rdy;
  assign mem_dout  = r_mem_dout;
  assign if_valid  = r_if_valid;
  assign if_data   = r_if_data;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_ctrl
// Brief    : Scoreboard bench for mem_arbiter_ctrl. Stimulus pushes expected
//            fetch lines, LSB completions and RAM writes; a negedge monitor
//            pops and compares whenever the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_ctrl;

  localparam int ADDR_W = 32;
  localparam int FB     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b1;
  logic              flush = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_valid;
  logic [8*FB-1:0]   if_data;
  logic              lsb_req = 1'b0;
  logic              lsb_we = 1'b0;
  logic [1:0]        lsb_size = 2'd0;
  logic [ADDR_W-1:0] lsb_addr = '0;
  logic [31:0]       lsb_wdata = '0;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  logic              io_buffer_full = 1'b0;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_fetch[$];
  logic [32:0] q_lsb[$];   // bit 32 set: load, compare rdata
  logic [39:0] q_wr[$];    // {address, byte}

  mem_arbiter_ctrl #(
    .ADDR_W(ADDR_W), .FETCH_BYTES(FB), .CNT_W(5), .IO_HI(2'b11)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
    .lsb_rdata(lsb_rdata), .io_buffer_full(io_buffer_full),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM image: a short program at 0x100, a simple address pattern elsewhere.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: ram_byte = 8'h13;
      32'h101: ram_byte = 8'h05;
      32'h102: ram_byte = 8'h00;
      32'h103: ram_byte = 8'h00;
      default: ram_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign mem_din = ram_byte(mem_a);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented fetch line, completion and write is scored.
  always @(negedge clk) begin
    logic [39:0] ew;
    logic [32:0] el;
    logic [31:0] ef;
    if (rst) begin
      if (if_valid) begin
        if (q_fetch.size() == 0) chk("spurious if_valid", {63'd0, if_valid}, 64'd0);
        else begin
          ef = q_fetch.pop_front();
          chk("if_data", {32'd0, if_data}, {32'd0, ef});
        end
      end
      if (lsb_done) begin
        if (q_lsb.size() == 0) chk("spurious lsb_done", {63'd0, lsb_done}, 64'd0);
        else begin
          el = q_lsb.pop_front();
          if (el[32]) chk("lsb_rdata", {32'd0, lsb_rdata}, {32'd0, el[31:0]});
        end
      end
      if (mem_wr) begin
        if (q_wr.size() == 0) chk("spurious write", {63'd0, mem_wr}, 64'd0);
        else begin
          ew = q_wr.pop_front();
          chk("write addr", {32'd0, mem_a}, {32'd0, ew[39:8]});
          chk("write byte", {56'd0, mem_dout}, {56'd0, ew[7:0]});
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input bit is_lsb, output int cyc);
    logic p;
    cyc = 0;
    do begin
      nxt();
      cyc++;
      p = is_lsb ? lsb_done : if_valid;
    end while ((p !== 1'b1) && (cyc < 60));
    if (p !== 1'b1) chk(is_lsb ? "lsb_done timeout" : "if_valid timeout", {63'd0, p}, 64'd1);
  endtask

  task automatic set_lsb(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    lsb_we = we; lsb_size = sz; lsb_addr = a; lsb_wdata = wd; lsb_req = 1'b1;
  endtask

  task automatic tie_fixed_order();
    int cyc;
    wait_pulse(1'b1, cyc); chk("tie lsb latency", cyc, 6); lsb_req = 1'b0;
    wait_pulse(1'b0, cyc); chk("tie fetch after gap", cyc, 7); if_req = 1'b0;
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset values
    rst = 1'b0;
    nxt(); nxt();
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst mem_a", {32'd0, mem_a}, 64'd0);
    chk("rst mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("rst if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst lsb_done", {63'd0, lsb_done}, 64'd0);
    rst = 1'b1;
    nxt();

    // Fetch 0x100: address trace then one-cycle pulse
    q_fetch.push_back(32'h0000_0513);
    if_addr = 32'h100; if_req = 1'b1;
    nxt();
    chk("fetch busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("fetch mem_a", {32'd0, mem_a}, 64'h100 + 64'(i));
    end
    nxt();
    chk("fetch pulse at 6", {63'd0, if_valid}, 64'd1);
    if_req = 1'b0;
    nxt();
    chk("if_valid one cycle", {63'd0, if_valid}, 64'd0);
    chk("idle after done", {63'd0, busy}, 64'd0);

    // Tie: LSB load at 0x40 wins, fetch after the gap cycle
    q_lsb.push_back({1'b1, 32'hE6E7_E4E5});
    q_fetch.push_back(32'h0000_0513);
    if_addr = 32'h100; if_req = 1'b1;
    set_lsb(1'b0, 2'd2, 32'h40, 32'h0);
    tie_fixed_order();

    // Halfword store
    q_wr.push_back({32'h2000, 8'hEF});
    q_wr.push_back({32'h2001, 8'hBE});
    q_lsb.push_back({1'b0, 32'h0});
    set_lsb(1'b1, 2'd1, 32'h2000, 32'h0000_BEEF);
    wait_pulse(1'b1, cyc); chk("store2 latency", cyc, 4);
    lsb_req = 1'b0; lsb_we = 1'b0;
    nxt(); nxt();

    // Single byte load; last grant now LSB
    q_lsb.push_back({1'b1, 32'h0000_00DA});
    set_lsb(1'b0, 2'd0, 32'h7F, 32'h0);
    wait_pulse(1'b1, cyc); chk("load1 latency", cyc, 3);
    lsb_req = 1'b0;
    nxt();

    // Second tie
    q_lsb.push_back({1'b1, 32'hE6E7_E4E5});
    q_fetch.push_back(32'h0000_0513);
    if_addr = 32'h100; if_req = 1'b1;
    set_lsb(1'b0, 2'd2, 32'h40, 32'h0);
`ifdef RR_ARB_EN
    wait_pulse(1'b0, cyc); chk("rr tie fetch first", cyc, 6); if_req = 1'b0;
    wait_pulse(1'b1, cyc); chk("rr tie lsb after gap", cyc, 7); lsb_req = 1'b0;
    nxt();
`else
    tie_fixed_order();
`endif

    // Flush after two captured fetch bytes
    if_addr = 32'h200; if_req = 1'b1;
    repeat (4) nxt();
    flush = 1'b1; if_req = 1'b0;
    nxt();
    chk("flush abort idle", {63'd0, busy}, 64'd0);
    chk("flush no if_valid", {63'd0, if_valid}, 64'd0);
    flush = 1'b0;
    repeat (8) nxt();

    // Flush during a word store is ignored
    q_wr.push_back({32'h2100, 8'h44});
    q_wr.push_back({32'h2101, 8'h33});
    q_wr.push_back({32'h2102, 8'h22});
    q_wr.push_back({32'h2103, 8'h11});
    q_lsb.push_back({1'b0, 32'h0});
    set_lsb(1'b1, 2'd2, 32'h2100, 32'h1122_3344);
    nxt(); nxt();
    flush = 1'b1;
    nxt(); nxt();
    flush = 1'b0;
    wait_pulse(1'b1, cyc); chk("store under flush", cyc, 2);
    lsb_req = 1'b0; lsb_we = 1'b0;
    nxt();

    // IO store held off by a full buffer for five cycles
    io_buffer_full = 1'b1;
    q_wr.push_back({32'h0003_0000, 8'h5A});
    q_lsb.push_back({1'b0, 32'h0});
    set_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("io stall mem_wr", {63'd0, mem_wr}, 64'd0);
    end
    io_buffer_full = 1'b0;
    wait_pulse(1'b1, cyc); chk("io store resume", cyc, 3);
    lsb_req = 1'b0; lsb_we = 1'b0;
    nxt();

    // IO load is single byte regardless of size
    q_lsb.push_back({1'b1, 32'h0000_00B5});
    set_lsb(1'b0, 2'd2, 32'h0003_0010, 32'h0);
    wait_pulse(1'b1, cyc); chk("io load latency", cyc, 3);
    lsb_req = 1'b0;
    nxt();

    // Fetch wrapping past the top of the address space
    q_fetch.push_back(32'hA4A5_5A5B);
    if_addr = 32'hFFFF_FFFE; if_req = 1'b1;
    wait_pulse(1'b0, cyc); chk("wrap fetch latency", cyc, 6);
    if_req = 1'b0;
    nxt();

    // rdy low for three cycles mid-fetch
    q_fetch.push_back(32'h0000_0513);
    if_addr = 32'h100; if_req = 1'b1;
    nxt(); nxt(); nxt();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("rdy0 mem_a held", {32'd0, mem_a}, 64'h101);
    end
    rdy = 1'b1;
    wait_pulse(1'b0, cyc); chk("rdy0 fetch latency", cyc, 3);
    if_req = 1'b0;
    nxt();

    // rdy low during a store suppresses the write strobe
    q_wr.push_back({32'h2200, 8'hFE});
    q_wr.push_back({32'h2201, 8'hCA});
    q_lsb.push_back({1'b0, 32'h0});
    set_lsb(1'b1, 2'd1, 32'h2200, 32'h0000_CAFE);
    nxt(); nxt();
    rdy = 1'b0;
    #1;
    chk("rdy0 gates mem_wr", {63'd0, mem_wr}, 64'd0);
    nxt();
    nxt();
    rdy = 1'b1;
    wait_pulse(1'b1, cyc); chk("rdy0 store latency", cyc, 2);
    lsb_req = 1'b0; lsb_we = 1'b0;
    nxt();

    // Asynchronous reset in the middle of a load
    set_lsb(1'b0, 2'd2, 32'h40, 32'h0);
    nxt(); nxt(); nxt();
    #2;
    rst = 1'b0;
    #1;
    chk("async rst busy", {63'd0, busy}, 64'd0);
    chk("async rst mem_a", {32'd0, mem_a}, 64'd0);
    chk("async rst mem_dout", {56'd0, mem_dout}, 64'd0);
    chk("async rst lsb_rdata", {32'd0, lsb_rdata}, 64'd0);
    chk("async rst if_data", {32'd0, if_data}, 64'd0);
    lsb_req = 1'b0;
    nxt();
    rst = 1'b1;
    repeat (10) nxt();

    chk("fetch queue drained", 64'(q_fetch.size()), 64'd0);
    chk("lsb queue drained", 64'(q_lsb.size()), 64'd0);
    chk("write queue drained", 64'(q_wr.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
